// File: rtl/change_dispenser.sv
// change_dispenser: greedy dime/nickel payout over 4-phase hopper handshakes with sticky fault.
// Optional CHANGE_COUNT_EN adds a saturating coins_paid counter port.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 255
`ifdef CHANGE_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soda,
  input  logic [2:0] change,
  output logic       dime_req,
  input  logic       dime_ack,
  input  logic       dime_empty,
  output logic       nickel_req,
  input  logic       nickel_ack,
  input  logic       nickel_empty,
  output logic       busy,
  output logic       done,
  output logic       vend_lost,
  output logic       fault
`ifdef CHANGE_COUNT_EN
  , output logic [CNT_W-1:0] coins_paid
`endif
);
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, DECIDE, DIME_REQ, DIME_REL, NICK_REQ, NICK_REL, DONE, FAULT} state_e;
  state_e state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [TW-1:0] timer_q, timer_d;
  logic dime_req_q, nickel_req_q, busy_q, done_q, vend_lost_q, fault_q;
  logic hs, timeout;
  assign hs = state_q inside {DIME_REQ, DIME_REL, NICK_REQ, NICK_REL};
  assign timeout = timer_q == TLAST;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (soda) begin
        state_d = DECIDE;
        rem_d = change;
      end
      DECIDE: state_d = (rem_q == 3'd0) ? DONE :
                        (rem_q >= 3'd2 && !dime_empty) ? DIME_REQ :
                        !nickel_empty ? NICK_REQ : FAULT;
      DIME_REQ: if (dime_ack) begin
        state_d = DIME_REL;
        rem_d = rem_q - 3'd2;
      end else if (timeout) state_d = FAULT;
      DIME_REL: state_d = !dime_ack ? DECIDE : timeout ? FAULT : DIME_REL;
      NICK_REQ: if (nickel_ack) begin
        state_d = NICK_REL;
        rem_d = rem_q - 3'd1;
      end else if (timeout) state_d = FAULT;
      NICK_REL: state_d = !nickel_ack ? DECIDE : timeout ? FAULT : NICK_REL;
      DONE: state_d = IDLE;
      default: state_d = FAULT;
    endcase
    // timer only runs inside a handshake and restarts on every state change
    timer_d = (!hs || state_d != state_q) ? '0 : timer_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      timer_q <= '0;
      dime_req_q <= 1'b0;
      nickel_req_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      vend_lost_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      timer_q <= timer_d;
      dime_req_q <= state_d == DIME_REQ;
      nickel_req_q <= state_d == NICK_REQ;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
      vend_lost_q <= soda && state_q != IDLE;
      fault_q <= state_d == FAULT;
    end
  end
  assign dime_req = dime_req_q;
  assign nickel_req = nickel_req_q;
  assign busy = busy_q;
  assign done = done_q;
  assign vend_lost = vend_lost_q;
  assign fault = fault_q;
`ifdef CHANGE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acked;
  assign acked = (state_q == DIME_REQ && dime_ack) || (state_q == NICK_REQ && nickel_ack);
  assign cnt_d = (acked && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign coins_paid = cnt_q;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized and directed payouts checked against a coin-count model.
module tb_change_dispenser;
  localparam int TO = 8;
  localparam int ACK_DLY = 2;
  logic clk = 0, rst_n = 0, soda = 0;
  logic [2:0] change = 0;
  logic dime_req, dime_ack = 0, dime_empty = 0;
  logic nickel_req, nickel_ack = 0, nickel_empty = 0;
  logic busy, done, vend_lost, fault;
  int checks = 0, errors = 0;
  bit dime_auto = 1, nick_auto = 1;
  int dime_cnt = 0, nick_cnt = 0, done_cnt = 0, vl_cnt = 0, overlap = 0, reraise = 0;
  logic dime_p = 0, nick_p = 0;
  int dd = 0, nd = 0;

  change_dispenser #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .soda(soda), .change(change),
    .dime_req(dime_req), .dime_ack(dime_ack), .dime_empty(dime_empty),
    .nickel_req(nickel_req), .nickel_ack(nickel_ack), .nickel_empty(nickel_empty),
    .busy(busy), .done(done), .vend_lost(vend_lost), .fault(fault));

  always #5 clk = ~clk;

  // hopper models: follow req with ACK_DLY cycles of latency on both edges
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin dime_ack = 0; dd = 0; end
    else if (dime_auto && dime_ack != dime_req) begin
      dd++;
      if (dd == ACK_DLY) begin dime_ack = dime_req; dd = 0; end
    end else dd = 0;
    if (!rst_n) begin nickel_ack = 0; nd = 0; end
    else if (nick_auto && nickel_ack != nickel_req) begin
      nd++;
      if (nd == ACK_DLY) begin nickel_ack = nickel_req; nd = 0; end
    end else nd = 0;
  end

  always @(negedge clk) begin
    if (dime_req && !dime_p) dime_cnt <= dime_cnt + 1;
    if (nickel_req && !nick_p) nick_cnt <= nick_cnt + 1;
    if ((dime_req && !dime_p && dime_ack) || (nickel_req && !nick_p && nickel_ack)) reraise <= reraise + 1;
    if (dime_req && nickel_req) overlap <= overlap + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (vend_lost) vl_cnt <= vl_cnt + 1;
    dime_p <= dime_req;
    nick_p <= nickel_req;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0;
    soda = 0;
    tick;
    tick;
    rst_n = 1;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if ({dime_req, nickel_req, busy, done, vend_lost, fault} !== 6'b0) begin
      errors++; $display("FAIL reset outputs got %b want 000000", {dime_req, nickel_req, busy, done, vend_lost, fault});
    end
  endtask

  task automatic run_payout(input logic [2:0] c, input bit de, input bit ne, input bit soda_mid);
    int ed, en, cyc, exp_vl, d0, n0, dn0, v0;
    bit ef;
    ed = de ? 0 : int'(c) / 2;
    en = int'(c) - 2 * ed;
    ef = (en > 0) && ne;
    if (ef) en = 0;
    d0 = dime_cnt; n0 = nick_cnt; dn0 = done_cnt; v0 = vl_cnt;
    exp_vl = 0;
    dime_empty = de; nickel_empty = ne;
    soda = 1; change = c;
    tick;
    soda = 0; change = 3'($urandom);
    cyc = 0;
    while (!done && !fault && cyc < 300) begin
      soda = soda_mid && cyc == 3 && busy;
      if (soda) exp_vl++;
      tick;
      cyc++;
    end
    soda = 0;
    checks++; if (cyc >= 300) begin errors++; $display("FAIL payout_timeout change=%0d got no done/fault within 300 cycles", c); end
    tick;
    checks++; if (fault !== ef) begin errors++; $display("FAIL payout_fault change=%0d de=%0d ne=%0d got %b want %b", c, de, ne, fault, ef); end
    checks++; if (dime_cnt - d0 != ed) begin errors++; $display("FAIL payout_dimes change=%0d de=%0d got %0d want %0d", c, de, dime_cnt - d0, ed); end
    checks++; if (nick_cnt - n0 != en) begin errors++; $display("FAIL payout_nickels change=%0d de=%0d ne=%0d got %0d want %0d", c, de, ne, nick_cnt - n0, en); end
    checks++; if (done_cnt - dn0 != (ef ? 0 : 1)) begin errors++; $display("FAIL payout_done change=%0d got %0d want %0d", c, done_cnt - dn0, ef ? 0 : 1); end
    checks++; if (vl_cnt - v0 != exp_vl) begin errors++; $display("FAIL payout_vend_lost got %0d want %0d", vl_cnt - v0, exp_vl); end
    checks++; if (busy !== ef) begin errors++; $display("FAIL payout_busy_after got %b want %b", busy, ef); end
    checks++; if (overlap != 0 || reraise != 0) begin errors++; $display("FAIL handshake_rules overlap=%0d reraise=%0d want 0 0", overlap, reraise); end
    if (ef) do_reset;
    dime_empty = 0; nickel_empty = 0;
  endtask

  task automatic test_directed;
    run_payout(3'd4, 0, 0, 0);
    run_payout(3'd3, 0, 0, 0);
    run_payout(3'd4, 1, 0, 0);
    run_payout(3'd7, 0, 0, 1);
    run_payout(3'd3, 0, 1, 0);
  endtask

  task automatic test_zero_change;
    int dn0;
    dn0 = done_cnt;
    soda = 1; change = 0;
    tick;
    soda = 0;
    checks++; if (busy !== 1 || done !== 0) begin errors++; $display("FAIL zero_n1 busy=%b done=%b want 1 0", busy, done); end
    tick;
    checks++; if (done !== 1 || dime_req !== 0 || nickel_req !== 0) begin errors++; $display("FAIL zero_n2 done=%b reqs=%b%b want 1 00", done, dime_req, nickel_req); end
    tick;
    checks++; if (done !== 0 || busy !== 0) begin errors++; $display("FAIL zero_n3 done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_nickel_fault;
    int n0;
    n0 = nick_cnt;
    nickel_empty = 1;
    soda = 1; change = 3'd1;
    tick;
    soda = 0;
    checks++; if (fault !== 0) begin errors++; $display("FAIL nfault_n1 fault=%b want 0", fault); end
    tick;
    checks++; if (fault !== 1 || busy !== 1) begin errors++; $display("FAIL nfault_n2 fault=%b busy=%b want 1 1", fault, busy); end
    nickel_empty = 0;
    repeat (3) tick;
    soda = 1; change = 3'd2;
    tick;
    soda = 0;
    checks++; if (vend_lost !== 1) begin errors++; $display("FAIL nfault_vend_lost got %b want 1", vend_lost); end
    tick;
    checks++; if (vend_lost !== 0 || fault !== 1 || dime_req !== 0 || nickel_req !== 0) begin
      errors++; $display("FAIL nfault_sticky vl=%b fault=%b reqs=%b%b want 0 1 00", vend_lost, fault, dime_req, nickel_req);
    end
    checks++; if (nick_cnt != n0) begin errors++; $display("FAIL nfault_no_req got %0d reqs want 0", nick_cnt - n0); end
    do_reset;
  endtask

  task automatic test_timeout;
    int hi;
    dime_auto = 0;
    soda = 1; change = 3'd2;
    tick;
    soda = 0;
    tick;
    hi = 0;
    while (dime_req && hi < 50) begin hi++; tick; end
    checks++; if (hi != TO) begin errors++; $display("FAIL timeout_req_cycles got %0d want %0d", hi, TO); end
    checks++; if (fault !== 1 || dime_req !== 0) begin errors++; $display("FAIL timeout_fault fault=%b req=%b want 1 0", fault, dime_req); end
    dime_auto = 1;
    do_reset;
  endtask

  task automatic test_reset_mid;
    int cyc;
    soda = 1; change = 3'd4;
    tick;
    soda = 0;
    cyc = 0;
    while (!dime_req && cyc < 20) begin tick; cyc++; end
    checks++; if (dime_req !== 1) begin errors++; $display("FAIL rstmid_req_seen got %b want 1", dime_req); end
    rst_n = 0;
    #1;
    checks++; if ({dime_req, nickel_req, busy, done, vend_lost, fault} !== 6'b0) begin
      errors++; $display("FAIL rstmid_outputs got %b want 000000", {dime_req, nickel_req, busy, done, vend_lost, fault});
    end
    tick;
    rst_n = 1;
    tick;
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      run_payout(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) run_payout(3'($urandom_range(0, 7)), 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_zero_change;
    test_directed;
    test_nickel_fault;
    test_timeout;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
